// File: rtl/nexi_wb_pkg.sv
// nexi_wb_pkg
//   Shared definitions for the NEXI Wishbone B3 initiator:
//   - Wishbone width constants (address, data, byte-select)
//   - response status codes returned on rsp_status_o
//   - initiator FSM state encoding
package nexi_wb_pkg;

  localparam int unsigned WB_ADR_W = 30;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_ERR       = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_RETRY_EXH = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_BACKOFF = 2'd2,
    S_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/nexi_wb_timeout.sv
// nexi_wb_timeout
//   Bus-cycle watchdog for the Wishbone initiator. Counts cycles in which a
//   strobe is outstanding without termination and flags expiry on the cycle
//   that would bring the count to the limit.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   clear_i    restart the count (asserted when a bus attempt begins)
//   enable_i   one unterminated strobe cycle is being counted this cycle
//   limit_i    number of unterminated strobe cycles allowed (1..65535)
//   expired_o  this counted cycle is the limit-th one
module nexi_wb_timeout (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [15:0] limit_i,
  output logic        expired_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Fires during the limit-th strobe cycle so the strobe drops on its edge.
  assign expired_o = enable_i && (count_q == (limit_i - 16'd1));

endmodule

// File: rtl/nexi_wb_master.sv
// nexi_wb_master
//   Single-outstanding command-to-Wishbone B3 initiator. A command accepted
//   on the cmd_* handshake is issued as one classic Wishbone cycle; RTY
//   terminations are retried after a one-cycle back-off up to MAX_RETRY
//   times, and the outcome is returned on the rsp_* handshake.
//   Optional bus watchdog: define NEXI_WB_MASTER_TIMEOUT_EN to abort cycles
//   that see no termination within TIMEOUT strobe cycles.
// Parameters:
//   TIMEOUT    unterminated strobe cycles before abort (1..65535)
//   MAX_RETRY  RTY terminations tolerated before failure (0..15)
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o         command handshake
//   cmd_we_i, cmd_addr_i,
//   cmd_data_i, cmd_sel_i           command fields (addr bits [1:0] ignored)
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_data_o, rsp_status_o        read data (0 unless OK read), status
//   adr_o, dat_o, dat_i, sel_o,
//   cyc_o, stb_o, we_o              Wishbone initiator signals
//   ack_i, err_i, rty_i             Wishbone terminations (err > rty > ack)
module nexi_wb_master
  import nexi_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_data_i,
  input  logic [3:0]          cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic [1:0]          rsp_status_o,
  output logic [WB_ADR_W-1:0] adr_o,
  output logic [WB_DAT_W-1:0] dat_o,
  input  logic [WB_DAT_W-1:0] dat_i,
  output logic [WB_SEL_W-1:0] sel_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i
);

  localparam logic [3:0]  MAX_RETRY_L = 4'(MAX_RETRY);
  localparam logic [15:0] TIMEOUT_L   = 16'(TIMEOUT);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [WB_DAT_W-1:0] rdata_q, rdata_d;
  logic [3:0]          retry_q;
  logic                retry_inc;
  logic                handshake;
  logic                bus_live;
  logic                term_any;
  logic                bus_enter;
  logic                timeout_hit;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr_i[1:0];

  assign cmd_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign handshake    = cmd_valid_i && cmd_ready_o;
  assign bus_live     = (state_q == S_BUS) && cyc_o && stb_o;
  assign term_any     = bus_live && (ack_i || err_i || rty_i);
  assign bus_enter    = (state_q != S_BUS) && (state_d == S_BUS);

  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_data_o   = rdata_q;
  assign rsp_status_o = status_q;

`ifdef NEXI_WB_MASTER_TIMEOUT_EN
  nexi_wb_timeout u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (bus_enter),
    .enable_i  (bus_live && !term_any),
    .limit_i   (TIMEOUT_L),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_L, bus_enter};
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    retry_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (handshake) state_d = S_BUS;
      end
      S_BUS: begin
        if (bus_live) begin
          if (err_i) begin
            state_d  = S_RESP;
            status_d = ST_ERR;
            rdata_d  = '0;
          end else if (rty_i) begin
            if (retry_q < MAX_RETRY_L) begin
              state_d   = S_BACKOFF;
              retry_inc = 1'b1;
            end else begin
              state_d  = S_RESP;
              status_d = ST_RETRY_EXH;
              rdata_d  = '0;
            end
          end else if (ack_i) begin
            state_d  = S_RESP;
            status_d = ST_OK;
            rdata_d  = we_o ? '0 : dat_i;
          end else if (timeout_hit) begin
            state_d  = S_RESP;
            status_d = ST_TIMEOUT;
            rdata_d  = '0;
          end
        end
      end
      S_BACKOFF: state_d = S_BUS;
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cyc/stb are registered copies of "next state is BUS", so they rise the
  // cycle after the handshake and fall on the terminating edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_o    <= '0;
      dat_o    <= '0;
      sel_o    <= '0;
      we_o     <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      retry_q  <= '0;
      status_q <= ST_OK;
      rdata_q  <= '0;
    end else begin
      if (handshake) begin
        adr_o   <= cmd_addr_i[31:2];
        dat_o   <= cmd_data_i;
        sel_o   <= cmd_sel_i;
        we_o    <= cmd_we_i;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 4'd1;
      end
      cyc_o    <= (state_d == S_BUS);
      stb_o    <= (state_d == S_BUS);
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_nexi_wb_master.sv
// tb_nexi_wb_master
//   Directed bench for nexi_wb_master (TIMEOUT=10, MAX_RETRY=3). The bench
//   plays the Wishbone slave, issues commands, and compares against
//   hand-computed expected values.
module tb_nexi_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_data_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_status_o;
  logic [29:0] adr_o;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, we_o, ack_i, err_i, rty_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [29:0] seen_adr;
  logic [31:0] seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we;

  int stb_cyc, bursts, gaps, lat;
  logic [31:0] hold_data;
  logic [1:0]  hold_status;

  always #5 clk_i = ~clk_i;

  nexi_wb_master #(
    .TIMEOUT   (10),
    .MAX_RETRY (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .cmd_sel_i    (cmd_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_status_o (rsp_status_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .sel_o        (sel_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .ack_i        (ack_i),
    .err_i        (err_i),
    .rty_i        (rty_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one command and plays the slave. kind: 0 = ACK, 1 = ERR+ACK
  // together, 2 = silent. The first `rtys` terminations are RTY. Each
  // termination comes on the (waits+1)-th strobe cycle of a burst.
  // lat counts edges from the handshake edge (inclusive) to rsp_valid_o,
  // or -1 if the budget runs out first. Returns at a falling edge.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int waits, input int rtys, input int kind,
                         input logic [31:0] rdata, input int budget,
                         output int o_stb, output int o_bursts, output int o_gaps, output int o_lat);
    int cnt;
    int left;
    logic prev_stb;
    o_stb = 0; o_bursts = 0; o_gaps = 0; o_lat = -1;
    cnt = 0; left = rtys; prev_stb = 1'b0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = wdata; cmd_sel_i = sel;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    for (int e = 0; e < budget; e++) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      if (rsp_valid_o) begin
        o_lat = e + 1;
        break;
      end
      if (cyc_o && stb_o) begin
        if (!prev_stb) begin
          o_bursts++;
          cnt = 0;
          seen_adr = adr_o; seen_dat = dat_o; seen_sel = sel_o; seen_we = we_o;
        end
        o_stb++;
        if (cnt == waits) begin
          if (left > 0) begin
            rty_i = 1'b1;
            left--;
          end else if (kind == 0) begin
            ack_i = 1'b1; dat_i = rdata;
          end else if (kind == 1) begin
            err_i = 1'b1; ack_i = 1'b1; dat_i = rdata;
          end
        end
        cnt++;
      end else if (o_bursts > 0) begin
        o_gaps++;
      end
      prev_stb = cyc_o && stb_o;
      @(negedge clk_i);
    end
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
  endtask

  task automatic consume(input string tag);
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid_o, 0);
    check({tag, "_ready_back"}, cmd_ready_o, 1);
  endtask

  // Called at a falling edge while a bus cycle is outstanding.
  task automatic mid_bus_reset();
    check("rst_busy_before", cyc_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_cyc_drop", cyc_o, 0);
    check("rst_stb_drop", stb_o, 0);
    check("rst_no_rsp", rsp_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_i = 1'b1; dat_i = 32'hA5A5A5A5;
    @(negedge clk_i);
    ack_i = 1'b0;
    check("late_ack_no_rsp", rsp_valid_o, 0);
    check("late_ack_no_cyc", cyc_o, 0);
    check("late_ack_idle", cmd_ready_o, 1);
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0;
    cmd_sel_i = '0; rsp_ready_i = 1'b0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_adr", adr_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_rsp_status", rsp_status_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_cmd_ready", cmd_ready_o, 1);

    // Single write, zero wait states.
    run_txn(1'b1, 32'h000010A0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 50, stb_cyc, bursts, gaps, lat);
    check("wr_adr", seen_adr, 32'h00000428);
    check("wr_dat", seen_dat, 32'hDEADBEEF);
    check("wr_sel", seen_sel, 4'hF);
    check("wr_we", seen_we, 1);
    check("wr_stb_cycles", stb_cyc, 1);
    check("wr_latency", lat, 2);
    check("wr_status", rsp_status_o, 2'b00);
    check("wr_data_zero", rsp_data_o, 0);
    check("wr_cyc_dropped", cyc_o, 0);
    consume("wr");

    // Read with three wait states; response held unconsumed for 5 cycles.
    run_txn(1'b0, 32'h00000004, 32'h0, 4'hF, 3, 0, 0, 32'h12345678, 50, stb_cyc, bursts, gaps, lat);
    check("rd_adr", seen_adr, 32'h00000001);
    check("rd_we", seen_we, 0);
    check("rd_stb_cycles", stb_cyc, 4);
    check("rd_latency", lat, 5);
    check("rd_data", rsp_data_o, 32'h12345678);
    check("rd_status", rsp_status_o, 2'b00);
    hold_data = rsp_data_o;
    hold_status = rsp_status_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_valid", rsp_valid_o, 1);
      check("hold_data", rsp_data_o, hold_data);
      check("hold_status", rsp_status_o, hold_status);
      check("hold_cmd_ready", cmd_ready_o, 0);
    end
    consume("rd");

    // Four RTYs: retries exhausted.
    run_txn(1'b0, 32'h00000100, 32'h11111111, 4'h3, 0, 4, 0, 32'h55555555, 50, stb_cyc, bursts, gaps, lat);
    check("rty4_bursts", bursts, 4);
    check("rty4_gaps", gaps, 3);
    check("rty4_stb_cycles", stb_cyc, 4);
    check("rty4_status", rsp_status_o, 2'b11);
    check("rty4_data", rsp_data_o, 0);
    check("rty4_latency", lat, 8);
    consume("rty4");

    // Three RTYs then ACK on a read.
    run_txn(1'b0, 32'h00000200, 32'h0, 4'hC, 0, 3, 0, 32'h0BADF00D, 50, stb_cyc, bursts, gaps, lat);
    check("rty3_bursts", bursts, 4);
    check("rty3_gaps", gaps, 3);
    check("rty3_adr_last", seen_adr, 32'h00000080);
    check("rty3_sel_last", seen_sel, 4'hC);
    check("rty3_status", rsp_status_o, 2'b00);
    check("rty3_data", rsp_data_o, 32'h0BADF00D);
    consume("rty3");

    // ERR and ACK together: ERR wins.
    run_txn(1'b0, 32'h00000300, 32'h0, 4'hF, 1, 0, 1, 32'hCAFEF00D, 50, stb_cyc, bursts, gaps, lat);
    check("err_status", rsp_status_o, 2'b01);
    check("err_data", rsp_data_o, 0);
    check("err_stb_cycles", stb_cyc, 2);
    consume("err");

`ifdef NEXI_WB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h00000040, 32'h0, 4'hF, 0, 0, 2, 32'h0, 50, stb_cyc, bursts, gaps, lat);
    check("to_stb_cycles", stb_cyc, 10);
    check("to_bursts", bursts, 1);
    check("to_latency", lat, 11);
    check("to_status", rsp_status_o, 2'b10);
    check("to_data", rsp_data_o, 0);
    check("to_cyc_low", cyc_o, 0);
    consume("to");
    run_txn(1'b0, 32'h00000044, 32'h0, 4'hF, 0, 0, 2, 32'h0, 5, stb_cyc, bursts, gaps, lat);
    check("pre_rst_no_rsp", lat, -1);
    mid_bus_reset();
`else
    run_txn(1'b0, 32'h00000040, 32'h0, 4'hF, 0, 0, 2, 32'h0, 1000, stb_cyc, bursts, gaps, lat);
    check("silent_no_rsp", lat, -1);
    check("silent_stb_cycles", stb_cyc, 1000);
    check("silent_cyc_high", cyc_o, 1);
    mid_bus_reset();
`endif

    // Transaction after reset still works.
    run_txn(1'b1, 32'h0000FFFC, 32'h01020304, 4'h1, 0, 0, 0, 32'h0, 50, stb_cyc, bursts, gaps, lat);
    check("post_rst_adr", seen_adr, 32'h00003FFF);
    check("post_rst_status", rsp_status_o, 2'b00);
    check("post_rst_latency", lat, 2);
    consume("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nexi_wb_master.md
NEXI_WB_MASTER -- requirements
Module: nexi_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, 255, bus cycles with STB high and no termination before abort (range 1..65535).
REQ-002 SHALL have parameter MAX_RETRY, 3, RTY terminations tolerated before reporting failure (range 0..15).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following command-side ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  32  byte address; bits [1:0] ignored.
- cmd_data_i  in  32  write data.
- cmd_sel_i  in  4  byte lane select.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_data_o  out  32  read data; 0 for writes and failures.
- rsp_status_o  out  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
REQ-005 SHALL have the following Wishbone B3 initiator ports:
- adr_o  out  30  word address.
- dat_o  out  32  write data.
- dat_i  in  32  read data.
- sel_o  out  4  byte select.
- cyc_o  out  1  cycle.
- stb_o  out  1  strobe.
- we_o  out  1  write enable.
- ack_i  in  1  normal termination.
- err_i  in  1  error termination.
- rty_i  in  1  retry termination.

Function
REQ-006 SHALL implement states IDLE, BUS, BACKOFF, RESP.
REQ-007 In IDLE, cmd_ready_o SHALL be 1; on handshake, command fields SHALL be latched, the retry count cleared, and the FSM SHALL move to BUS.
REQ-008 In BUS, cyc_o, stb_o, adr_o, dat_o, sel_o and we_o SHALL be registered, stable, and asserted starting one cycle after the handshake.
REQ-009 Termination SHALL be sampled only when cyc_o and stb_o are high; if several terminations are asserted together, priority SHALL be err_i > rty_i > ack_i.
REQ-010 On ack_i: dat_i SHALL be captured (reads only), status set to OK, cyc_o/stb_o dropped on the next edge, and the FSM SHALL move to RESP.
REQ-011 On err_i: status SHALL be ERR, rsp_data_o 0, and the FSM SHALL move to RESP.
REQ-012 On rty_i with retry count < MAX_RETRY: the count SHALL increment and the FSM SHALL move to BACKOFF, holding cyc_o/stb_o low for exactly 1 cycle before re-entering BUS with identical fields.
REQ-013 On rty_i with retry count = MAX_RETRY: status SHALL be RETRY_EXHAUSTED and the FSM SHALL move to RESP.
REQ-014 In RESP, rsp_valid_o SHALL be 1 and response fields SHALL stay stable until rsp_ready_i; after that the FSM SHALL return to IDLE.
REQ-015 Minimum latency: handshake at edge N, STB high from N+1, ACK at N+1 gives rsp_valid_o from N+2.
REQ-016 cmd_ready_o SHALL be 0 in every state except IDLE; at most one transaction SHALL be outstanding.
REQ-017 dat_o SHALL be driven with the latched data for reads too; slaves ignore it.

Reset
REQ-018 When rst_i is high at an edge: FSM to IDLE; cyc_o, stb_o, we_o = 0; adr_o, dat_o, sel_o, rsp_data_o, rsp_status_o = 0; rsp_valid_o = 0; cmd_ready_o = 0 during reset and 1 in the first cycle after.
REQ-019 Reset mid-cycle SHALL drop cyc_o/stb_o on the next edge with no response generated; an ack_i arriving afterwards SHALL be ignored.

Configuration
REQ-020 With macro NEXI_WB_MASTER_TIMEOUT_EN defined:
- a 16-bit counter SHALL clear on entering BUS and increment each BUS cycle without termination;
- at count = TIMEOUT, cyc_o/stb_o SHALL drop and the FSM SHALL go to RESP with status TIMEOUT;
- a termination on the same cycle as the timeout SHALL win.
REQ-021 Without NEXI_WB_MASTER_TIMEOUT_EN: no counter SHALL exist, BUS SHALL wait indefinitely, and status TIMEOUT SHALL never be produced.

Structure
REQ-022 Package nexi_wb_pkg SHALL hold the status code constants, the FSM state encoding, and the Wishbone width constants (ADR 30, DAT 32, SEL 4).
REQ-023 The timeout counter SHALL be sub-module nexi_wb_timeout (clear, enable, limit in; expired out), instantiated only under the macro.

Verification
REQ-024 Write 0x000010A0, data 0xDEADBEEF, sel 0xF, slave ACKs on first STB cycle -> adr_o = 0x0000428, one STB cycle, rsp_status 00, rsp_valid two cycles after handshake.
REQ-025 Read 0x00000004, slave returns 0x12345678 after 3 wait states -> rsp_data 0x12345678, status 00, STB high exactly 4 cycles.
REQ-026 MAX_RETRY = 3, slave asserts RTY 4 times -> four STB bursts separated by 1-cycle gaps, status 11; with 3 RTYs then ACK -> status 00.
REQ-027 ERR and ACK asserted together -> status 01, rsp_data 0.
REQ-028 Macro defined, TIMEOUT = 10, silent slave -> cyc_o drops after 10 STB cycles, status 10; macro undefined -> cyc_o still high after 1000 cycles.
REQ-029 Hold rsp_ready_i low for 5 cycles -> rsp_valid_o and data stay stable and cmd_ready_o stays 0; assert rst_i mid-BUS -> cyc_o low next edge and no response.
